// File: rtl/q_inverse_table.sv
// rtl/q_inverse_table.sv - inverse lookup tables for the Twofish q0/q1 byte permutations
//
// After reset the block sweeps x = 0..255 through q0 and q1 and writes
// inv0[q0(x)] = x and inv1[q1(x)] = x. It then serves lookups over a
// valid/ready stream with 1-cycle latency and a 1-per-clock throughput.
//
// Optional feature macro: Q_INV_CHECK_EN
//   defined   - every result is pushed back through q0/q1 one cycle after the
//               accept and compared with the requested y; a mismatch sets the
//               sticky chk_err flag until reset.
//   undefined - no check logic, chk_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   init_done  out  tables built, lookups accepted
//   in_valid   in   lookup request valid
//   in_ready   out  request accepted when in_valid & in_ready
//   in_sel     in   0 = invert q0, 1 = invert q1
//   in_y       in   permuted byte to invert
//   out_valid  out  result valid
//   out_ready  in   result consumed when out_valid & out_ready
//   out_x      out  preimage byte
//   out_sel    out  in_sel echoed with the result
//   chk_err    out  sticky round-trip mismatch flag
module q_inverse_table #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic              out_sel,
  output logic              chk_err
);

  // Twofish q-box nibble tables, entry i stored in bits [4*i +: 4].
  localparam logic [63:0] Q0_T0 = 64'h4ACE95B0_23F6D718;
  localparam logic [63:0] Q0_T1 = 64'hD9076A4F_53218BCE;
  localparam logic [63:0] Q0_T2 = 64'h17423F8C_09D6E5AB;
  localparam logic [63:0] Q0_T3 = 64'hAC5803B9_E6214F7D;
  localparam logic [63:0] Q1_T0 = 64'h5CA04913_E67FDB82;
  localparam logic [63:0] Q1_T1 = 64'h809F5AD6_73C4B2E1;
  localparam logic [63:0] Q1_T2 = 64'hF3B28DE0_A96157C4;
  localparam logic [63:0] Q1_T3 = 64'hA802F746_ED3C159B;

  typedef enum logic {
    FILL  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] inv0 [DEPTH];
  logic [DATA_W-1:0] inv1 [DEPTH];
  logic [7:0]        fill_y0, fill_y1;
  logic [DATA_W-1:0] rd_x;
  logic              accept;

  function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
    return tbl[{idx, 2'b00} +: 4];
  endfunction

  // One q permutation: two rounds of nibble mixing (a ^ ror4(b,1) ^ 8a mod 16)
  // followed by the 4-bit sboxes; the output byte is {b4, a4}.
  function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = nib(sel ? Q1_T0 : Q0_T0, a1);
    b2 = nib(sel ? Q1_T1 : Q0_T1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = nib(sel ? Q1_T2 : Q0_T2, a3);
    b4 = nib(sel ? Q1_T3 : Q0_T3, b3);
    return {b4, a4};
  endfunction

  assign fill_y0   = q_perm(1'b0, cnt_q);
  assign fill_y1   = q_perm(1'b1, cnt_q);
  assign init_done = (state_q == SERVE);
  assign in_ready  = init_done & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign rd_x      = in_sel ? inv1[in_y] : inv0[in_y];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == FILL) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        state_d = SERVE;
      end
    end
  end

  // Tables carry no reset: a FILL pass rewrites every entry, since q0/q1 are bijective.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == FILL)) begin
      inv0[fill_y0] <= cnt_q;
      inv1[fill_y1] <= cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_sel   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_x     <= rd_x;
      out_sel   <= in_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef Q_INV_CHECK_EN
  logic [7:0] chk_y_q;
  logic       chk_pend_q;
  logic       chk_err_q;

  // chk_pend_q marks the cycle in which out_x holds a freshly accepted result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_y_q    <= 8'd0;
      chk_pend_q <= 1'b0;
      chk_err_q  <= 1'b0;
    end else begin
      chk_pend_q <= accept;
      if (accept) begin
        chk_y_q <= in_y;
      end
      if (chk_pend_q && (q_perm(out_sel, out_x) != chk_y_q)) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_q_inverse_table.sv
// tb/tb_q_inverse_table.sv - self-checking bench for q_inverse_table
module tb_q_inverse_table;

  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic [7:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic       out_sel;
  logic       chk_err;

  int total = 0;
  int bad   = 0;

  q_inverse_table dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_sel   (out_sel),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int q0t0[16] = '{8, 1, 7, 13, 6, 15, 3, 2, 0, 11, 5, 9, 14, 12, 10, 4};
  int q0t1[16] = '{14, 12, 11, 8, 1, 2, 3, 5, 15, 4, 10, 6, 7, 0, 9, 13};
  int q0t2[16] = '{11, 10, 5, 14, 6, 13, 9, 0, 12, 8, 15, 3, 2, 4, 7, 1};
  int q0t3[16] = '{13, 7, 15, 4, 1, 2, 6, 14, 9, 11, 3, 0, 8, 5, 12, 10};
  int q1t0[16] = '{2, 8, 11, 13, 15, 7, 6, 14, 3, 1, 9, 4, 0, 10, 12, 5};
  int q1t1[16] = '{1, 14, 2, 11, 4, 12, 3, 7, 6, 13, 10, 5, 15, 9, 0, 8};
  int q1t2[16] = '{4, 12, 7, 5, 1, 6, 9, 10, 0, 14, 13, 8, 2, 11, 3, 15};
  int q1t3[16] = '{11, 9, 5, 1, 12, 3, 13, 14, 6, 4, 7, 15, 2, 0, 8, 10};

  function automatic int tlook(int sel, int k, int i);
    case (k)
      0:       return (sel != 0) ? q1t0[i] : q0t0[i];
      1:       return (sel != 0) ? q1t1[i] : q0t1[i];
      2:       return (sel != 0) ? q1t2[i] : q0t2[i];
      default: return (sel != 0) ? q1t3[i] : q0t3[i];
    endcase
  endfunction

  function automatic int ror1(int v);
    return (v >> 1) | ((v & 1) << 3);
  endfunction

  // Forward q0/q1 in plain integer arithmetic.
  function automatic int qf(int sel, int x);
    int a, b, a2, b2;
    a  = x / 16;
    b  = x % 16;
    a2 = tlook(sel, 0, a ^ b);
    b2 = tlook(sel, 1, a ^ ror1(b) ^ ((8 * a) % 16));
    a  = tlook(sel, 2, a2 ^ b2);
    b  = tlook(sel, 3, a2 ^ ror1(b2) ^ ((8 * a2) % 16));
    return 16 * b + a;
  endfunction

  int m_inv0[256];
  int m_inv1[256];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour, advanced on each rising edge from the bench-driven inputs.
  bit m_on = 0;
  int m_fill;
  bit m_init, m_valid, m_sel, m_chk, m_pend;
  int m_x, m_y;

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      m_on = 1; m_fill = 0; m_init = 0; m_valid = 0;
      m_x = 0; m_sel = 0; m_chk = 0; m_pend = 0; m_y = 0;
    end else if (m_on) begin
      if (m_pend && (qf(m_sel, m_x) != m_y)) m_chk = 1;
      acc    = m_init && in_valid && (!m_valid || out_ready);
      m_pend = acc;
      if (!m_init) begin
        m_fill++;
        if (m_fill == 256) m_init = 1;
      end else if (acc) begin
        m_x     = in_sel ? m_inv1[in_y] : m_inv0[in_y];
        m_sel   = in_sel;
        m_y     = in_y;
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("cyc_init_done", int'(init_done), int'(m_init));
      check("cyc_in_ready",  int'(in_ready),  int'(m_init && (!m_valid || out_ready)));
      check("cyc_out_valid", int'(out_valid), int'(m_valid));
      check("cyc_out_x",     int'(out_x),     m_x);
      check("cyc_out_sel",   int'(out_sel),   int'(m_sel));
`ifdef Q_INV_CHECK_EN
      check("cyc_chk_err",   int'(chk_err),   int'(m_chk));
`else
      check("cyc_chk_err",   int'(chk_err),   0);
`endif
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered at edge+1; returns at edge+1 once init_done rose or the budget ran out.
  task automatic wait_init(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!init_done && n < 300);
    check(name, n, 256);
  endtask

  task automatic lookup(input string name, input bit sel, input int y, input int exp);
    in_valid = 1; in_sel = sel; in_y = y[7:0]; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_x"}, int'(out_x), exp);
  endtask

  initial begin
    int res;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 256; x++)
        if (s == 0) m_inv0[qf(0, x)] = x; else m_inv1[qf(1, x)] = x;

    check("model_q0_0", qf(0, 0), 'hA9);
    check("model_q0_1", qf(0, 1), 'h67);
    check("model_q1_0", qf(1, 0), 'h75);
    check("model_q1_1", qf(1, 1), 'hF3);

    rst_n = 0; in_valid = 0; in_sel = 0; in_y = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("t1_rst_init_done", int'(init_done), 0);
    check("t1_rst_out_valid", int'(out_valid), 0);
    check("t1_rst_out_x", int'(out_x), 0);
    rst_n = 1;
    wait_init("t1_init_latency");

    lookup("t2_q0_a9", 0, 'hA9, 'h00);
    lookup("t2_q0_67", 0, 'h67, 'h01);
    lookup("t2_q1_75", 1, 'h75, 'h00);
    lookup("t2_q1_f3", 1, 'hF3, 'h01);
    @(posedge clk); #1;

    res = 0;
    for (int s = 0; s < 2; s++) begin
      for (int y = 0; y < 256; y++) begin
        in_valid = 1; in_sel = s[0]; in_y = y[7:0];
        @(posedge clk); #1;
        if (out_valid && (qf(int'(out_sel), int'(out_x)) == y) && (int'(out_sel) == s)) res++;
      end
    end
    in_valid = 0;
    check("t3_results", res, 512);
    check("t3_chk_err", int'(chk_err), 0);
    @(posedge clk); #1;

    in_valid = 1; in_sel = 0; in_y = 8'hA9; out_ready = 0;
    @(posedge clk); #1;
    in_y = 8'h67;
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_ready", int'(in_ready), 0);
      check("t4_stall_x", int'(out_x), 'h00);
      check("t4_stall_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    #1;
    check("t4_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    check("t4_next_x", int'(out_x), 'h01);
    check("t4_next_valid", int'(out_valid), 1);

    out_ready = 0;
    rst_n = 0;
    @(posedge clk); #1;
    check("t5a_out_valid", int'(out_valid), 0);
    rst_n = 1; out_ready = 1;
    wait_init("t5a_init_latency");

    in_valid = 1; in_sel = 1; in_y = 8'h75;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (100) @(posedge clk);
    #1;
    check("t5b_fill_ready", int'(in_ready), 0);
    rst_n = 0; in_valid = 0;
    @(posedge clk); #1;
    check("t5b_init_done", int'(init_done), 0);
    check("t5b_out_valid", int'(out_valid), 0);
    rst_n = 1;
    wait_init("t5b_init_latency");
    lookup("t5b_q1_f3", 1, 'hF3, 'h01);
    @(posedge clk); #1;

`ifdef Q_INV_CHECK_EN
    dut.inv0[8'h3C] = 8'h5A;
    m_inv0[8'h3C] = 'h5A;
    lookup("t6_corrupt", 0, 'h3C, 'h5A);
    check("t6_chk_1clk", int'(chk_err), 0);
    @(posedge clk); #1;
    check("t6_chk_2clk", int'(chk_err), 1);
    repeat (4) @(posedge clk);
    #1;
    check("t6_chk_sticky", int'(chk_err), 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
